// File: rtl/y86_pkg.sv
// Y86-64 shared constants: status codes, instruction codes, register ids
// and the write-back status FSM encoding.
package y86_pkg;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] ICODE_HALT   = 4'd0;
    localparam logic [3:0] ICODE_NOP    = 4'd1;
    localparam logic [3:0] ICODE_CMOVXX = 4'd2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'd3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'd4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'd5;
    localparam logic [3:0] ICODE_OPQ    = 4'd6;
    localparam logic [3:0] ICODE_JXX    = 4'd7;
    localparam logic [3:0] ICODE_CALL   = 4'd8;
    localparam logic [3:0] ICODE_RET    = 4'd9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'd10;
    localparam logic [3:0] ICODE_POPQ   = 4'd11;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'd4;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } wb_state_e;

    // Undefined status encodings are folded into INS.
    function automatic logic [2:0] norm_stat(input logic [2:0] s);
        logic [2:0] r;
        r = STAT_INS;
        if (s == STAT_AOK || s == STAT_HLT || s == STAT_ADR)
            r = s;
        return r;
    endfunction

endpackage

// File: rtl/gpr_file.sv
// General-purpose register file: two write ports (M over E on collision)
// and two combinational read ports with optional same-cycle forwarding.
module gpr_file #(
    parameter int XLEN   = 64,
    parameter int RW     = 4,
    parameter int NREGS  = 15,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we_e_i,
    input  logic [RW-1:0]   waddr_e_i,
    input  logic [XLEN-1:0] wdata_e_i,
    input  logic            we_m_i,
    input  logic [RW-1:0]   waddr_m_i,
    input  logic [XLEN-1:0] wdata_m_i,
    input  logic [RW-1:0]   raddr_a_i,
    input  logic [RW-1:0]   raddr_b_i,
    output logic [XLEN-1:0] rdata_a_o,
    output logic [XLEN-1:0] rdata_b_o
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (we_m_i && waddr_m_i == RW'(i))
                    regs_q[i] <= wdata_m_i;
                else if (we_e_i && waddr_e_i == RW'(i))
                    regs_q[i] <= wdata_e_i;
            end
        end
    end

    // Out-of-range indices (including RNONE) match no entry and read 0.
    function automatic logic [XLEN-1:0] rd(input logic [RW-1:0] a);
        logic [XLEN-1:0] r;
        r = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (a == RW'(i))
                r = regs_q[i];
        end
        if (BYPASS != 0) begin
            if (we_e_i && waddr_e_i == a)
                r = wdata_e_i;
            if (we_m_i && waddr_m_i == a)
                r = wdata_m_i;
        end
        return r;
    endfunction

    always_comb begin
        rdata_a_o = rd(raddr_a_i);
        rdata_b_o = rd(raddr_b_i);
    end

endmodule

// File: rtl/wb_regfile_ctl.sv
// Y86-64 write-back stage: commit decode, status/halt FSM,
// retired-instruction counter and the GPR file.
module wb_regfile_ctl
    import y86_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int RW        = 4,
    parameter int NREGS     = 15,
    parameter int BYPASS    = 1,
    parameter int CMOV_GATE = 1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w_valid,
    input  logic             w_stall,
    input  logic [2:0]       w_stat,
    input  logic [3:0]       w_icode,
    input  logic             w_cnd,
    input  logic [RW-1:0]    w_dstE,
    input  logic [RW-1:0]    w_dstM,
    input  logic [XLEN-1:0]  w_valE,
    input  logic [XLEN-1:0]  w_valM,
    input  logic             restart,
    input  logic [RW-1:0]    srcA,
    input  logic [RW-1:0]    srcB,
    output logic [XLEN-1:0]  valA,
    output logic [XLEN-1:0]  valB,
    output logic [2:0]       stat_o,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [RW-1:0] RN      = '1;
    localparam logic [RW:0]   NREGS_W = (RW + 1)'(NREGS);

    wb_state_e        state_q;
    logic [2:0]       stat_q;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] retired_d;

    logic       commit;
    logic [2:0] stat_n;
    logic       stat_ok;
    logic       cmov_block;
    logic       dste_ok;
    logic       dstm_ok;
    logic       we_e;
    logic       we_m;
    logic       retire;

    assign halted  = (state_q == ST_HALTED);
    assign stat_o  = stat_q;
    assign retired = retired_q;

    // Reset also suppresses forwarding so outputs read 0 while held.
    always_comb begin
        commit     = rst_n & w_valid & ~w_stall & ~halted;
        stat_n     = norm_stat(w_stat);
        stat_ok    = (stat_n == STAT_AOK);
        cmov_block = (CMOV_GATE != 0) && (w_icode == ICODE_CMOVXX) && !w_cnd;
        dste_ok    = (w_dstE != RN) && ({1'b0, w_dstE} < NREGS_W);
        dstm_ok    = (w_dstM != RN) && ({1'b0, w_dstM} < NREGS_W);
        we_e       = commit & stat_ok & dste_ok & ~cmov_block;
        we_m       = commit & stat_ok & dstm_ok;
        retire     = commit & (stat_ok | (stat_n == STAT_HLT));
    end

    always_comb begin
        retired_d = retired_q;
        if (retire && retired_q != '1)
            retired_d = retired_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            stat_q    <= STAT_AOK;
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
            case (state_q)
                ST_RUN: begin
                    if (!restart && commit && !stat_ok) begin
                        state_q <= ST_HALTED;
                        stat_q  <= stat_n;
                    end
                end
                ST_HALTED: begin
                    if (restart) begin
                        state_q <= ST_RUN;
                        stat_q  <= STAT_AOK;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    stat_q  <= STAT_AOK;
                end
            endcase
        end
    end

    gpr_file #(
        .XLEN   (XLEN),
        .RW     (RW),
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_gpr (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_e_i    (we_e),
        .waddr_e_i (w_dstE),
        .wdata_e_i (w_valE),
        .we_m_i    (we_m),
        .waddr_m_i (w_dstM),
        .wdata_m_i (w_valM),
        .raddr_a_i (srcA),
        .raddr_b_i (srcB),
        .rdata_a_o (valA),
        .rdata_b_o (valB)
    );

endmodule

// File: tb/tb_wb_regfile_ctl.sv
// Bench for wb_regfile_ctl: two instances (default, and no-bypass/no-gate/
// 2-bit counter) checked every cycle against an architectural model.
module tb_wb_regfile_ctl;

    localparam int XLEN  = 64;
    localparam int RW    = 4;
    localparam int NREGS = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            w_valid;
    logic            w_stall;
    logic [2:0]      w_stat;
    logic [3:0]      w_icode;
    logic            w_cnd;
    logic [RW-1:0]   w_dstE;
    logic [RW-1:0]   w_dstM;
    logic [XLEN-1:0] w_valE;
    logic [XLEN-1:0] w_valM;
    logic            restart;
    logic [RW-1:0]   srcA;
    logic [RW-1:0]   srcB;

    logic [XLEN-1:0] valA0, valB0, valA1, valB1;
    logic [2:0]      stat0, stat1;
    logic            halt0, halt1;
    logic [31:0]     ret0;
    logic [1:0]      ret1;

    wb_regfile_ctl dut0 (
        .clk(clk), .rst_n(rst_n), .w_valid(w_valid), .w_stall(w_stall),
        .w_stat(w_stat), .w_icode(w_icode), .w_cnd(w_cnd),
        .w_dstE(w_dstE), .w_dstM(w_dstM), .w_valE(w_valE), .w_valM(w_valM),
        .restart(restart), .srcA(srcA), .srcB(srcB),
        .valA(valA0), .valB(valB0), .stat_o(stat0), .halted(halt0),
        .retired(ret0)
    );

    wb_regfile_ctl #(.BYPASS(0), .CMOV_GATE(0), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .w_valid(w_valid), .w_stall(w_stall),
        .w_stat(w_stat), .w_icode(w_icode), .w_cnd(w_cnd),
        .w_dstE(w_dstE), .w_dstM(w_dstM), .w_valE(w_valE), .w_valM(w_valM),
        .restart(restart), .srcA(srcA), .srcB(srcB),
        .valA(valA1), .valB(valB1), .stat_o(stat1), .halted(halt1),
        .retired(ret1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Architectural model: instance 0 bypass+gate, instance 1 neither.
    logic [63:0] mr [2][NREGS];
    logic [2:0]  ms [2];
    bit          mh [2];
    longint      mret [2];

    function automatic bit is_def(int k);
        return k == 0;
    endfunction

    function automatic longint rmax(int k);
        return (k == 0) ? 64'hFFFF_FFFF : 64'd3;
    endfunction

    function automatic bit mcommit(int k);
        return w_valid && !w_stall && !mh[k];
    endfunction

    function automatic bit mwe_e(int k);
        return mcommit(k) && w_stat == 3'd1 && int'(w_dstE) < NREGS &&
               !(is_def(k) && w_icode == 4'd2 && !w_cnd);
    endfunction

    function automatic bit mwe_m(int k);
        return mcommit(k) && w_stat == 3'd1 && int'(w_dstM) < NREGS;
    endfunction

    function automatic logic [63:0] mread(int k, logic [3:0] s);
        if (int'(s) >= NREGS) return 64'd0;
        if (is_def(k)) begin
            if (mwe_m(k) && w_dstM == s) return w_valM;
            if (mwe_e(k) && w_dstE == s) return w_valE;
        end
        return mr[k][s];
    endfunction

    function automatic longint mret_exp(int k);
        return (mret[k] > rmax(k)) ? rmax(k) : mret[k];
    endfunction

    task automatic mstep(int k);
        bit c, e, m;
        c = mcommit(k);
        e = mwe_e(k);
        m = mwe_m(k);
        if (e) mr[k][w_dstE] = w_valE;
        if (m) mr[k][w_dstM] = w_valM;
        if (c) begin
            if (w_stat == 3'd1) begin
                mret[k]++;
            end else begin
                ms[k] = (w_stat >= 3'd2 && w_stat <= 3'd4) ? w_stat : 3'd4;
                mh[k] = 1'b1;
                if (w_stat == 3'd2) mret[k]++;
            end
        end
        if (restart) begin
            mh[k] = 1'b0;
            ms[k] = 3'd1;
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NREGS; i++) mr[k][i] = 64'd0;
            ms[k]   = 3'd1;
            mh[k]   = 1'b0;
            mret[k] = 0;
        end
    endtask

    // Per-cycle comparison against the model, then model update at the edge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst_n) begin
                chk("valA0", valA0, mread(0, srcA));
                chk("valB0", valB0, mread(0, srcB));
                chk("stat0", 64'(stat0), 64'(ms[0]));
                chk("halt0", 64'(halt0), 64'(mh[0]));
                chk("ret0", 64'(ret0), 64'(mret_exp(0)));
                chk("valA1", valA1, mread(1, srcA));
                chk("valB1", valB1, mread(1, srcB));
                chk("stat1", 64'(stat1), 64'(ms[1]));
                chk("halt1", 64'(halt1), 64'(mh[1]));
                chk("ret1", 64'(ret1), 64'(mret_exp(1)));
            end
            @(posedge clk);
            if (!rst_n) begin
                mreset();
            end else begin
                mstep(0);
                mstep(1);
            end
        end
    end

    task automatic drive(input bit v, input bit st, input logic [2:0] s,
                         input logic [3:0] ic, input bit c,
                         input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm,
                         input bit rs, input logic [3:0] sa,
                         input logic [3:0] sb);
        w_valid = v;  w_stall = st; w_stat = s;  w_icode = ic;
        w_cnd   = c;  w_dstE  = de; w_valE = ve; w_dstM  = dm;
        w_valM  = vm; restart = rs; srcA   = sa; srcB    = sb;
    endtask

    task automatic cyc(input bit v, input bit st, input logic [2:0] s,
                       input logic [3:0] ic, input bit c,
                       input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm,
                       input bit rs, input logic [3:0] sa);
        @(negedge clk);
        drive(v, st, s, ic, c, de, ve, dm, vm, rs, sa, 4'hF);
    endtask

    task automatic idle(input logic [3:0] sa);
        cyc(0, 0, 3'd1, 4'd1, 0, 4'hF, 64'd0, 4'hF, 64'd0, 0, sa);
    endtask

    initial begin
        drive(0, 0, 3'd1, 4'd1, 0, 4'hF, 64'd0, 4'hF, 64'd0, 0, 4'd3, 4'hF);
        @(negedge clk);
        #3;
        chk("rst_stat", 64'(stat0), 64'd1);
        chk("rst_halt", 64'(halt0), 64'd0);
        chk("rst_ret", 64'(ret0), 64'd0);
        chk("rst_valA", valA0, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // irmovq $0x10, %rbx
        cyc(1, 0, 3'd1, 4'd3, 0, 4'd3, 64'h10, 4'hF, 64'd0, 0, 4'd3);
        idle(4'd3);
        #3;
        chk("irmov_valA", valA0, 64'h10);
        chk("irmov_ret", 64'(ret0), 64'd1);

        // popq %rsp: valM wins over valE
        cyc(1, 0, 3'd1, 4'd11, 0, 4'd4, 64'h108, 4'd4, 64'hAB, 0, 4'd4);
        #3;
        chk("pop_byp0", valA0, 64'hAB);
        chk("pop_nobyp1", valA1, 64'd0);
        idle(4'd4);
        #3;
        chk("pop_valA0", valA0, 64'hAB);
        chk("pop_valA1", valA1, 64'hAB);

        // cmovxx not taken, then taken
        cyc(1, 0, 3'd1, 4'd2, 0, 4'd5, 64'd7, 4'hF, 64'd0, 0, 4'd5);
        #3;
        chk("cmov0_byp", valA0, 64'd0);
        idle(4'd5);
        #3;
        chk("cmov0_reg", valA0, 64'd0);
        chk("cmov0_nogate", valA1, 64'd7);
        cyc(1, 0, 3'd1, 4'd2, 1, 4'd5, 64'd7, 4'hF, 64'd0, 0, 4'd5);
        idle(4'd5);
        #3;
        chk("cmov1_reg", valA0, 64'd7);
        chk("cmov_ret", 64'(ret0), 64'd4);

        // ADR halts, blocks writes until restart
        cyc(1, 0, 3'd1, 4'd3, 0, 4'd1, 64'h55, 4'hF, 64'd0, 0, 4'd1);
        cyc(1, 0, 3'd3, 4'd3, 0, 4'd1, 64'h99, 4'hF, 64'd0, 0, 4'd1);
        idle(4'd1);
        #3;
        chk("adr_reg", valA0, 64'h55);
        chk("adr_stat", 64'(stat0), 64'd3);
        chk("adr_halt", 64'(halt0), 64'd1);
        chk("adr_ret", 64'(ret0), 64'd5);
        cyc(1, 0, 3'd1, 4'd3, 0, 4'd1, 64'h77, 4'hF, 64'd0, 0, 4'd1);
        idle(4'd1);
        #3;
        chk("halt_blk", valA0, 64'h55);
        cyc(1, 0, 3'd1, 4'd3, 0, 4'd1, 64'h66, 4'hF, 64'd0, 1, 4'd1);
        idle(4'd1);
        #3;
        chk("rs_stat", 64'(stat0), 64'd1);
        chk("rs_halt", 64'(halt0), 64'd0);
        chk("rs_blk", valA0, 64'h55);
        cyc(1, 0, 3'd1, 4'd3, 0, 4'd1, 64'h77, 4'hF, 64'd0, 0, 4'd1);
        idle(4'd1);
        #3;
        chk("rs_write", valA0, 64'h77);
        chk("rs_ret", 64'(ret0), 64'd6);

        // HLT retires and halts; stall and bubble change nothing
        cyc(1, 0, 3'd2, 4'd0, 0, 4'hF, 64'd0, 4'hF, 64'd0, 0, 4'd2);
        idle(4'd2);
        #3;
        chk("hlt_ret", 64'(ret0), 64'd7);
        chk("hlt_halt", 64'(halt0), 64'd1);
        chk("hlt_stat", 64'(stat0), 64'd2);
        cyc(0, 0, 3'd1, 4'd1, 0, 4'hF, 64'd0, 4'hF, 64'd0, 1, 4'd2);
        cyc(1, 1, 3'd1, 4'd3, 0, 4'd2, 64'h33, 4'hF, 64'd0, 0, 4'd2);
        #3;
        chk("stall_byp", valA0, 64'd0);
        cyc(0, 0, 3'd1, 4'd3, 0, 4'd2, 64'h33, 4'hF, 64'd0, 0, 4'd2);
        idle(4'd2);
        #3;
        chk("stall_reg", valA0, 64'd0);
        chk("stall_ret", 64'(ret0), 64'd7);
        chk("sat_ret1", 64'(ret1), 64'd3);

        // Reset asserted in the middle of a commit cycle
        cyc(1, 0, 3'd1, 4'd3, 0, 4'd6, 64'hEE, 4'hF, 64'd0, 0, 4'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valA", valA0, 64'd0);
        chk("mrst_reg1", 64'(dut0.u_gpr.regs_q[1]), 64'd0);
        chk("mrst_ret0", 64'(ret0), 64'd0);
        chk("mrst_ret1", 64'(ret1), 64'd0);
        chk("mrst_stat", 64'(stat0), 64'd1);
        @(negedge clk);
        drive(0, 0, 3'd1, 4'd1, 0, 4'hF, 64'd0, 4'hF, 64'd0, 0, 4'd6, 4'hF);
        rst_n = 1'b1;
        #3;
        chk("mrst_drop", valA0, 64'd0);

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 6) == 0,
                  ($urandom_range(0, 15) != 0) ? 3'd1
                                               : 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? 4'd2
                                              : 4'($urandom_range(0, 11)),
                  $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)),
                  {$urandom, $urandom},
                  4'($urandom_range(0, 15)),
                  {$urandom, $urandom},
                  $urandom_range(0, 7) == 0,
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
        end
        @(negedge clk);
        #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
